mux_scan: RTL

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_next_ch.sv | 33 +++
 rtl/mux_scan.sv | 105 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared state encodings and width helper for the channel mux/scanner.
package mux_pkg;

    localparam logic [1:0] MANUAL = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Finds the next enabled channel above ptr, wrapping through 0; ptr itself is
// checked last so a lone enabled channel maps onto itself with wrap set.
module mux_next_ch
    import mux_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] nxt,
    output logic            wrap
);

    int   idx;
    logic found;

    always_comb begin
        nxt   = ptr;
        wrap  = 1'b0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(ptr) + i) % NCH;
            if (!found && mask[idx[SELW-1:0]]) begin
                found = 1'b1;
                nxt   = idx[SELW-1:0];
                wrap  = (idx <= int'(ptr));
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel mux with manual select or masked round-robin scan.
// state  | meaning
// MANUAL | dout follows sel when that channel is legal
// SCAN   | ptr walks enabled channels, DWELL cycles each
// HOLD   | scan requested but no channel enabled; outputs frozen, vld low
module mux_scan
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int DWELL = 4,
    localparam int SELW  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       mask,
    input  logic [NCH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]     dout,
    output logic [SELW-1:0]      ch,
    output logic                 vld,
    output logic                 wrap
);

    logic [1:0]       state;
    logic [1:0]       nxt_state;
    logic [SELW-1:0]  ptr;
    logic [7:0]       dcnt;
    logic [SELW-1:0]  base;
    logic [SELW-1:0]  srch_ch;
    logic [SELW-1:0]  pick;
    logic             srch_wrap;
    logic             sel_ok;
    logic             advance;
    logic [WIDTH-1:0] chan [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign chan[k] = din[k*WIDTH +: WIDTH];
    end

    // Outside SCAN the search starts just below channel 0, yielding the lowest enabled channel.
    mux_next_ch #(.NCH(NCH)) u_next (
        .mask (mask),
        .ptr  (base),
        .nxt  (srch_ch),
        .wrap (srch_wrap)
    );

    always_comb begin
        base      = (state == SCAN) ? ptr : SELW'(NCH - 1);
        sel_ok    = (int'(sel) < NCH) && mask[sel];
        nxt_state = !mode ? MANUAL : ((|mask) ? SCAN : HOLD);
        advance   = (state != SCAN) || !mask[ptr] || (dcnt == 8'(DWELL - 1));
        pick      = sel;
        if (nxt_state == SCAN) begin
            pick = advance ? srch_ch : ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MANUAL;
            ptr   <= '0;
            dcnt  <= '0;
            dout  <= '0;
            ch    <= '0;
            vld   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                state <= nxt_state;
                case (nxt_state)
                    SCAN: begin
                        vld  <= 1'b1;
                        dout <= chan[pick];
                        ch   <= pick;
                        if (advance) begin
                            ptr  <= srch_ch;
                            dcnt <= '0;
                            wrap <= (state == SCAN) && srch_wrap;
                        end else begin
                            dcnt <= dcnt + 8'd1;
                        end
                    end
                    HOLD: begin
                        vld  <= 1'b0;
                        dcnt <= '0;
                    end
                    default: begin
                        dcnt <= '0;
                        vld  <= sel_ok;
                        if (sel_ok) begin
                            dout <= chan[pick];
                            ch   <= pick;
                        end
                    end
                endcase
            end
        end
    end

endmodule
